// File: rtl/controle_busca.sv
// -----------------------------------------------------------------------------
// controle_busca -- instruction-fetch sequencer
//
// Drives the program counter through single-cycle strobes (clear / load /
// increment) and the instruction memory read port.  One memory read is issued
// per PC value.  The fetched word is handed to the decoder over a valid/ready
// handshake, after which the PC is advanced or redirected.
//
// Ports
//   relogio, reiniciar_n    clock (rising edge) / asynchronous active-low reset
//   habilitar               1 = keep fetching; 0 = stop at the next boundary
//   limpar                  synchronous flush: clear PC, drop in-flight work
//   pc_atual                current PC value (from the PC register)
//   pc_reiniciar            PC clear strobe
//   pc_carregar/pc_entrada  PC load strobe and load value
//   pc_soma                 PC increment strobe
//   mem_req/mem_end         memory read request and address (= pc_atual)
//   mem_ack/mem_dado        read data valid / read data
//   instr_valida/instr_pronta  handshake towards the decoder
//   instr/instr_end         fetched word and the address it came from
//   desvio_req/desvio_alvo  redirect request and target
//   desvio_ack              1-cycle pulse: redirect accepted
//   erro                    sticky memory-timeout fault
//
// Timing notes
//   The PC strobes and desvio_ack are decoded from the registered state and
//   the current-cycle inputs.  They have to be: the PC register updates on the
//   edge that ends the strobe cycle, so the BUSCA state entered on that same
//   edge already sees the new pc_atual.  This is what gives 2 cycles per
//   instruction.  A registered strobe would make the next BUSCA read a stale
//   PC, and would acknowledge a held desvio_req twice.
//   mem_req, instr_valida, erro, instr and instr_end are true registers.
// -----------------------------------------------------------------------------
module controle_busca #(
    parameter int                 LARGURA       = 16,
    parameter int                 LARGURA_INSTR = 16,
    parameter logic [LARGURA-1:0] END_INICIAL   = '0,
    parameter int                 LIMITE_ESPERA = 255
) (
    input  logic                     relogio,
    input  logic                     reiniciar_n,
    input  logic                     habilitar,
    input  logic                     limpar,
    input  logic [LARGURA-1:0]       pc_atual,
    output logic                     pc_reiniciar,
    output logic                     pc_carregar,
    output logic                     pc_soma,
    output logic [LARGURA-1:0]       pc_entrada,
    output logic                     mem_req,
    output logic [LARGURA-1:0]       mem_end,
    input  logic                     mem_ack,
    input  logic [LARGURA_INSTR-1:0] mem_dado,
    output logic                     instr_valida,
    input  logic                     instr_pronta,
    output logic [LARGURA_INSTR-1:0] instr,
    output logic [LARGURA-1:0]       instr_end,
    input  logic                     desvio_req,
    input  logic [LARGURA-1:0]       desvio_alvo,
    output logic                     desvio_ack,
    output logic                     erro
);

    // Wait counter holds 0 .. LIMITE_ESPERA-1.  The fault fires on the
    // LIMITE_ESPERA-th consecutive BUSCA cycle without an ack.
    localparam int             LC     = (LIMITE_ESPERA > 1) ? $clog2(LIMITE_ESPERA) : 1;
    localparam logic [LC-1:0]  ULTIMO = LC'(LIMITE_ESPERA - 1);

    typedef enum logic [2:0] {
        INICIO  = 3'd0,
        OCIOSO  = 3'd1,
        BUSCA   = 3'd2,
        ENTREGA = 3'd3,
        ERRO    = 3'd4
    } estado_t;

    estado_t        estado;
    logic [LC-1:0]  espera;

    // limpar acts everywhere except in INICIO and in the sticky fault state.
    logic flush;
    assign flush = limpar && (estado == OCIOSO || estado == BUSCA || estado == ENTREGA);

    // Handshake decisions taken while a word is on offer (priority: flush,
    // redirect, accept).
    logic desvia_entrega, aceita_entrega;
    assign desvia_entrega = (estado == ENTREGA) && !limpar && desvio_req;
    assign aceita_entrega = (estado == ENTREGA) && !limpar && !desvio_req && instr_pronta;

    // Redirect while idle.
    logic desvia_ocioso;
    assign desvia_ocioso = (estado == OCIOSO) && !limpar && desvio_req;

    // ------------------------------------------------------------------
    // State machine plus the registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge relogio or negedge reiniciar_n) begin
        if (!reiniciar_n) begin
            estado       <= INICIO;
            mem_req      <= 1'b0;
            instr_valida <= 1'b0;
            erro         <= 1'b0;
            instr        <= '0;
            instr_end    <= '0;
            espera       <= '0;
        end else begin
            case (estado)
                INICIO: begin
                    estado <= OCIOSO;
                end

                OCIOSO: begin
                    // A redirect taken here keeps us idle for that cycle, so
                    // the fetch that follows sees the loaded PC.
                    if (!limpar && !desvio_req && habilitar) begin
                        estado  <= BUSCA;
                        mem_req <= 1'b1;
                        espera  <= '0;
                    end
                end

                BUSCA: begin
                    if (limpar) begin
                        // The outstanding read is abandoned.  A late ack
                        // lands in OCIOSO, where mem_ack is not looked at.
                        estado  <= OCIOSO;
                        mem_req <= 1'b0;
                    end else if (mem_ack) begin
                        instr        <= mem_dado;
                        instr_end    <= pc_atual;
                        estado       <= ENTREGA;
                        mem_req      <= 1'b0;
                        instr_valida <= 1'b1;
                    end else if (espera == ULTIMO) begin
                        estado  <= ERRO;
                        mem_req <= 1'b0;
                        erro    <= 1'b1;
                    end else begin
                        espera <= espera + LC'(1);
                    end
                end

                ENTREGA: begin
                    if (limpar) begin
                        estado       <= OCIOSO;
                        instr_valida <= 1'b0;
                    end else if (desvio_req || instr_pronta) begin
                        // Both a redirect (word dropped) and an accept end
                        // the offer.  The PC strobe issued this cycle takes
                        // effect on this edge.
                        instr_valida <= 1'b0;
                        if (habilitar) begin
                            estado  <= BUSCA;
                            mem_req <= 1'b1;
                            espera  <= '0;
                        end else begin
                            estado <= OCIOSO;
                        end
                    end
                end

                ERRO: begin
                    // Only reiniciar_n leaves this state.
                    estado <= ERRO;
                end

                default: begin
                    estado       <= INICIO;
                    mem_req      <= 1'b0;
                    instr_valida <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PC strobes and redirect acknowledge.
    // The three strobes come from mutually exclusive branches, so at most
    // one of them is high in any cycle.
    // ------------------------------------------------------------------
    always_comb begin
        pc_reiniciar = 1'b0;
        pc_carregar  = 1'b0;
        pc_soma      = 1'b0;
        pc_entrada   = '0;
        desvio_ack   = 1'b0;

        if (estado == INICIO) begin
            // Gated by the reset input so that every output is 0 while
            // reset is held.
            if (reiniciar_n) begin
                pc_carregar = 1'b1;
                pc_entrada  = END_INICIAL;
            end
        end else if (flush) begin
            pc_reiniciar = 1'b1;
        end else if (desvia_ocioso || desvia_entrega) begin
            pc_carregar = 1'b1;
            pc_entrada  = desvio_alvo;
            desvio_ack  = 1'b1;
        end else if (aceita_entrega) begin
            pc_soma = 1'b1;
        end
    end

    // The address follows the PC for as long as the request is up.  Because
    // the PC only moves on a strobe, and no strobe is issued in BUSCA except
    // for a flush, the address is stable until the ack.
    assign mem_end = mem_req ? pc_atual : '0;

endmodule

// File: tb/tb_controle_busca.sv
// -----------------------------------------------------------------------------
// tb_controle_busca -- scoreboard bench for controle_busca.
//
// Two instances share the environment.  Only the selected one is released
// from reset:
//   u_a: END_INICIAL=0000, LIMITE_ESPERA=255
//   u_b: END_INICIAL=FFFF, LIMITE_ESPERA=4
// The bench models the PC register, a memory with programmable ack delay
// (data = address ^ 5A3C), and a decoder with programmable ready delay.
// The stimulus pushes the expected event stream.  A separate monitor pops one
// entry per observed event:
//   REINI, CARGA(value), DACK, REQ(address), INSTR(word, address),
//   SOMA(pc), ERRO
// Within a cycle, events are observed in that order.
// -----------------------------------------------------------------------------
module tb_controle_busca;
    localparam int W = 16;

    localparam int K_REINI = 0;
    localparam int K_CARGA = 1;
    localparam int K_DACK  = 2;
    localparam int K_REQ   = 3;
    localparam int K_INSTR = 4;
    localparam int K_SOMA  = 5;
    localparam int K_ERRO  = 6;

    typedef struct {
        int           kind;
        logic [W-1:0] val;
        logic [W-1:0] ende;
    } ev_t;

    ev_t esperado[$];
    int  total = 0;
    int  bad   = 0;

    logic         relogio = 1'b0;
    logic         rst_n, sel;
    logic         habilitar, limpar;
    logic [W-1:0] pc = '0;
    logic         mem_ack, instr_pronta, desvio_req;
    logic [W-1:0] mem_dado, desvio_alvo;

    // Environment knobs.
    bit mem_on, ack_forcado, desvio_arm, desvio_livre;
    int atraso, pronta_atraso;
    int espera_mem = 0;
    int vcnt       = 0;

    // Outputs of each instance, and the selected view.
    logic         pr_a, pcg_a, ps_a, req_a, iv_a, dack_a, er_a;
    logic [W-1:0] pe_a, me_a, in_a, ie_a;
    logic         pr_b, pcg_b, ps_b, req_b, iv_b, dack_b, er_b;
    logic [W-1:0] pe_b, me_b, in_b, ie_b;
    logic         pc_reiniciar, pc_carregar, pc_soma, mem_req, instr_valida, desvio_ack, erro;
    logic [W-1:0] pc_entrada, mem_end, instr, instr_end;
    logic         rst_a, rst_b;

    assign rst_a = rst_n & ~sel;
    assign rst_b = rst_n & sel;

    assign pc_reiniciar = sel ? pr_b   : pr_a;
    assign pc_carregar  = sel ? pcg_b  : pcg_a;
    assign pc_soma      = sel ? ps_b   : ps_a;
    assign mem_req      = sel ? req_b  : req_a;
    assign instr_valida = sel ? iv_b   : iv_a;
    assign desvio_ack   = sel ? dack_b : dack_a;
    assign erro         = sel ? er_b   : er_a;
    assign pc_entrada   = sel ? pe_b   : pe_a;
    assign mem_end      = sel ? me_b   : me_a;
    assign instr        = sel ? in_b   : in_a;
    assign instr_end    = sel ? ie_b   : ie_a;

    function automatic logic [W-1:0] dado(input logic [W-1:0] a);
        return a ^ 16'h5A3C;
    endfunction

    assign mem_ack      = ack_forcado | (mem_on & mem_req & (espera_mem == atraso));
    assign mem_dado     = dado(mem_end);
    assign instr_pronta = instr_valida & (vcnt >= pronta_atraso);
    assign desvio_req   = desvio_arm & (instr_valida | desvio_livre);

    controle_busca #(.LARGURA(16), .LARGURA_INSTR(16), .END_INICIAL(16'h0000), .LIMITE_ESPERA(255)) u_a (
        .relogio(relogio), .reiniciar_n(rst_a), .habilitar(habilitar), .limpar(limpar),
        .pc_atual(pc), .pc_reiniciar(pr_a), .pc_carregar(pcg_a), .pc_soma(ps_a), .pc_entrada(pe_a),
        .mem_req(req_a), .mem_end(me_a), .mem_ack(mem_ack), .mem_dado(mem_dado),
        .instr_valida(iv_a), .instr_pronta(instr_pronta), .instr(in_a), .instr_end(ie_a),
        .desvio_req(desvio_req), .desvio_alvo(desvio_alvo), .desvio_ack(dack_a), .erro(er_a)
    );

    controle_busca #(.LARGURA(16), .LARGURA_INSTR(16), .END_INICIAL(16'hFFFF), .LIMITE_ESPERA(4)) u_b (
        .relogio(relogio), .reiniciar_n(rst_b), .habilitar(habilitar), .limpar(limpar),
        .pc_atual(pc), .pc_reiniciar(pr_b), .pc_carregar(pcg_b), .pc_soma(ps_b), .pc_entrada(pe_b),
        .mem_req(req_b), .mem_end(me_b), .mem_ack(mem_ack), .mem_dado(mem_dado),
        .instr_valida(iv_b), .instr_pronta(instr_pronta), .instr(in_b), .instr_end(ie_b),
        .desvio_req(desvio_req), .desvio_alvo(desvio_alvo), .desvio_ack(dack_b), .erro(er_b)
    );

    always #5 relogio = ~relogio;

    // PC register, memory wait counter and decoder ready counter.
    always @(posedge relogio) begin
        espera_mem <= (mem_req && !mem_ack) ? espera_mem + 1 : 0;
        vcnt       <= (instr_valida && !instr_pronta) ? vcnt + 1 : 0;
        if (pc_reiniciar)     pc <= '0;
        else if (pc_carregar) pc <= pc_entrada;
        else if (pc_soma)     pc <= pc + 16'd1;
    end

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", nome, got, want, $time);
        end
    endtask

    task automatic push(input int k, input logic [W-1:0] v, input logic [W-1:0] e);
        ev_t x;
        x.kind = k; x.val = v; x.ende = e;
        esperado.push_back(x);
    endtask

    task automatic obs(input int k, input logic [W-1:0] v, input logic [W-1:0] e);
        ev_t x;
        total++;
        if (esperado.size() == 0) begin
            bad++;
            $display("FAIL evento: got kind=%0d val=%h end=%h want nothing t=%0t", k, v, e, $time);
        end else begin
            x = esperado.pop_front();
            if (x.kind != k || x.val !== v || x.ende !== e) begin
                bad++;
                $display("FAIL evento: got kind=%0d val=%h end=%h want kind=%0d val=%h end=%h t=%0t",
                         k, v, e, x.kind, x.val, x.ende, $time);
            end
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(posedge relogio);
        #1;
    endtask

    task automatic espera_dack(input string nome);
        bit visto;
        visto = 1'b0;
        for (int i = 0; i < 20 && !visto; i++) begin
            @(negedge relogio);
            if (desvio_ack) visto = 1'b1;
        end
        total++;
        if (!visto) begin
            bad++;
            $display("FAIL %s: got no desvio_ack want ack within 20 cycles", nome);
        end
        @(posedge relogio);
        #1;
    endtask

    // ---------------- monitor ----------------
    int           last_req = 0, last_val = 0;
    logic         req_ant = 1'b0, val_ant = 1'b0, erro_ant = 1'b0;
    logic [W-1:0] end_ant = '0, instr_ant = '0;

    initial begin
        int cur_req, cur_val;
        cur_req = 0; cur_val = 0;
        forever begin
            @(negedge relogio);
            if (rst_n) begin
                if (pc_reiniciar) obs(K_REINI, '0, '0);
                if (pc_carregar)  obs(K_CARGA, pc_entrada, '0);
                if (desvio_ack)   obs(K_DACK, '0, '0);
                if (mem_req && !req_ant) obs(K_REQ, mem_end, '0);
                if (instr_valida && instr_pronta && !desvio_req) obs(K_INSTR, instr, instr_end);
                if (pc_soma)      obs(K_SOMA, pc, '0);
                if (erro && !erro_ant) obs(K_ERRO, '0, '0);
                if (mem_req && req_ant) chk("mem_end_estavel", 32'(mem_end), 32'(end_ant));
                if (instr_valida && val_ant) chk("instr_estavel", 32'(instr), 32'(instr_ant));
                if (pc_reiniciar | pc_carregar | pc_soma)
                    chk("strobe_unico", 32'($countones({pc_reiniciar, pc_carregar, pc_soma})), 32'd1);
            end
            if (mem_req) cur_req++;
            else if (cur_req > 0) begin last_req = cur_req; cur_req = 0; end
            if (instr_valida) cur_val++;
            else if (cur_val > 0) begin last_val = cur_val; cur_val = 0; end
            req_ant   = mem_req;
            val_ant   = instr_valida;
            erro_ant  = erro;
            end_ant   = mem_end;
            instr_ant = instr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus want end before 100000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; sel = 1'b0; habilitar = 1'b0; limpar = 1'b0;
        mem_on = 1'b1; ack_forcado = 1'b0; desvio_arm = 1'b0; desvio_livre = 1'b0;
        atraso = 0; pronta_atraso = 0; desvio_alvo = '0;
        ciclos(3);
        chk("rst_pc_carregar", 32'(pc_carregar), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_instr_valida", 32'(instr_valida), 0);
        chk("rst_erro", 32'(erro), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_instr_end", 32'(instr_end), 0);

        // 1: sequential fetch, immediate ack, decoder always ready.
        push(K_CARGA, 16'h0000, '0);
        for (int a = 0; a < 3; a++) begin
            push(K_REQ, 16'(a), '0);
            push(K_INSTR, dado(16'(a)), 16'(a));
            push(K_SOMA, 16'(a), '0);
        end
        habilitar = 1'b1;
        rst_n = 1'b1;
        ciclos(7);
        habilitar = 1'b0;
        ciclos(2);

        // 2: ack 5 cycles late, decoder stalls 3 cycles.
        push(K_REQ, 16'h0003, '0);
        push(K_INSTR, dado(16'h0003), 16'h0003);
        push(K_SOMA, 16'h0003, '0);
        atraso = 5; pronta_atraso = 3; habilitar = 1'b1;
        ciclos(8);
        habilitar = 1'b0;
        ciclos(5);
        chk("req_ciclos_atraso5", 32'(last_req), 6);
        chk("valida_ciclos_pronta3", 32'(last_val), 4);

        // 3: redirect while a word is offered and accepted in the same cycle.
        push(K_REQ, 16'h0004, '0);
        push(K_CARGA, 16'h0100, '0);
        push(K_DACK, '0, '0);
        push(K_REQ, 16'h0100, '0);
        push(K_INSTR, dado(16'h0100), 16'h0100);
        push(K_SOMA, 16'h0100, '0);
        atraso = 0; pronta_atraso = 0; desvio_alvo = 16'h0100; desvio_arm = 1'b1; habilitar = 1'b1;
        espera_dack("desvio_entrega");
        desvio_arm = 1'b0; habilitar = 1'b0;
        ciclos(3);
        chk("pc_apos_desvio", 32'(pc), 32'h0101);

        // 4: flush during BUSCA, then a stray ack.
        push(K_REQ, 16'h0101, '0);
        push(K_REINI, '0, '0);
        mem_on = 1'b0; habilitar = 1'b1;
        ciclos(2);
        limpar = 1'b1; habilitar = 1'b0;
        ciclos(1);
        chk("mem_req_apos_limpar", 32'(mem_req), 0);
        limpar = 1'b0; ack_forcado = 1'b1;
        ciclos(1);
        ack_forcado = 1'b0; mem_on = 1'b1;
        chk("valida_apos_ack_tardio", 32'(instr_valida), 0);
        chk("pc_apos_limpar", 32'(pc), 0);
        ciclos(1);
        chk("valida_apos_ack_tardio2", 32'(instr_valida), 0);

        // 4b: redirect while idle, then fetch from the target.
        push(K_CARGA, 16'h0200, '0);
        push(K_DACK, '0, '0);
        push(K_REQ, 16'h0200, '0);
        push(K_INSTR, dado(16'h0200), 16'h0200);
        push(K_SOMA, 16'h0200, '0);
        desvio_livre = 1'b1; desvio_alvo = 16'h0200; desvio_arm = 1'b1;
        espera_dack("desvio_ocioso");
        desvio_arm = 1'b0; desvio_livre = 1'b0; habilitar = 1'b1;
        ciclos(1);
        habilitar = 1'b0;
        ciclos(3);

        // 6: END_INICIAL=FFFF wraps to 0000; reset lands mid-ENTREGA.
        rst_n = 1'b0; sel = 1'b1; habilitar = 1'b1; atraso = 0; pronta_atraso = 2; mem_on = 1'b1;
        push(K_CARGA, 16'hFFFF, '0);
        push(K_REQ, 16'hFFFF, '0);
        push(K_INSTR, dado(16'hFFFF), 16'hFFFF);
        push(K_SOMA, 16'hFFFF, '0);
        push(K_REQ, 16'h0000, '0);
        ciclos(2);
        rst_n = 1'b1;
        ciclos(8);
        chk("valida_antes_reset", 32'(instr_valida), 1);
        chk("instr_end_wrap", 32'(instr_end), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_assinc_valida", 32'(instr_valida), 0);
        chk("reset_assinc_instr", 32'(instr), 0);
        chk("reset_assinc_instr_end", 32'(instr_end), 0);
        chk("reset_assinc_mem_req", 32'(mem_req), 0);
        chk("reset_assinc_strobes", 32'({pc_reiniciar, pc_carregar, pc_soma, desvio_ack}), 0);

        // 5: LIMITE_ESPERA=4 and the memory never answers.
        mem_on = 1'b0; pronta_atraso = 0;
        push(K_CARGA, 16'hFFFF, '0);
        push(K_REQ, 16'hFFFF, '0);
        push(K_ERRO, '0, '0);
        ciclos(2);
        rst_n = 1'b1;
        ciclos(5);
        chk("erro_antes_limite", 32'(erro), 0);
        chk("mem_req_antes_limite", 32'(mem_req), 1);
        ciclos(1);
        chk("erro_no_limite", 32'(erro), 1);
        chk("mem_req_em_erro", 32'(mem_req), 0);
        limpar = 1'b1;
        ciclos(2);
        chk("pc_reiniciar_em_erro", 32'(pc_reiniciar), 0);
        chk("req_ciclos_ate_erro", 32'(last_req), 4);
        limpar = 1'b0;
        ciclos(2);
        chk("erro_persistente", 32'(erro), 1);
        rst_n = 1'b0;
        #1;
        chk("erro_limpo_reset", 32'(erro), 0);
        ciclos(2);
        chk("scoreboard_vazio", 32'(esperado.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
